// File: rtl/sym_classifier.sv
// sym_classifier: registered symbol classifier with saturating per-class counters
// and a MATCH-run detector. One-deep output register behind a valid/ready handshake.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   in_valid, in_data, in_ready producer side (in_ready = !out_valid | out_ready)
//   out_valid, out_class,
//   out_data, out_ready         consumer side; class 00 ZERO, 01 MATCH, 10 OVER, 11 OTHER
//   hit                         one-cycle pulse with the output of the RUN_LEN-th MATCH
//   cnt_match/zero/over         saturating per-class counts
//   cnt_clr                     synchronous clear of all counters
//
// Build option: define SYM_CLASSIFIER_DISPLAY_EN for simulation-only accept/hit messages.
module sym_classifier #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MATCH_VAL = 32'h01,
  parameter int unsigned THRESH    = 32'h01,
  parameter int unsigned RUN_LEN   = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [1:0]       out_class,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             hit,
  output logic [CNT_W-1:0] cnt_match,
  output logic [CNT_W-1:0] cnt_zero,
  output logic [CNT_W-1:0] cnt_over,
  input  logic             cnt_clr
);

  localparam int unsigned RUN_W = $clog2(RUN_LEN + 1);

  localparam logic [WIDTH-1:0] MATCH_V  = WIDTH'(MATCH_VAL);
  localparam logic [WIDTH-1:0] THRESH_V = WIDTH'(THRESH);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_LEN);

  localparam logic [1:0] CLS_ZERO  = 2'b00;
  localparam logic [1:0] CLS_MATCH = 2'b01;
  localparam logic [1:0] CLS_OVER  = 2'b10;
  localparam logic [1:0] CLS_OTHER = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HIT  = 2'd2;

  logic [1:0]       state_q, state_n;
  logic [RUN_W-1:0] run_q, run_n;
  logic             hit_n;
  logic             valid_n;
  logic [1:0]       class_n;
  logic [WIDTH-1:0] data_n;
  logic [CNT_W-1:0] cm_n, cz_n, co_n;
  logic             accept_c;
  logic [1:0]       class_c;
  logic [RUN_W-1:0] run_inc_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Output register frees up whenever it is empty or being drained this cycle.
  assign in_ready  = !out_valid | out_ready;
  assign accept_c  = in_valid & in_ready;
  assign run_inc_c = run_q + RUN_W'(1);

  // Priority classification; MATCH wins over ZERO when MATCH_VAL is zero.
  always_comb begin
    class_c = CLS_OTHER;
    if (in_data == MATCH_V)       class_c = CLS_MATCH;
    else if (in_data == '0)       class_c = CLS_ZERO;
    else if (in_data > THRESH_V)  class_c = CLS_OVER;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      run_q     <= '0;
      hit       <= 1'b0;
      out_valid <= 1'b0;
      out_class <= CLS_ZERO;
      out_data  <= '0;
      cnt_match <= '0;
      cnt_zero  <= '0;
      cnt_over  <= '0;
    end else begin
      state_q   <= state_n;
      run_q     <= run_n;
      hit       <= hit_n;
      out_valid <= valid_n;
      out_class <= class_n;
      out_data  <= data_n;
      cnt_match <= cm_n;
      cnt_zero  <= cz_n;
      cnt_over  <= co_n;
    end
  end

  // Next-state, output and counter logic.
  always_comb begin
    state_n = state_q;
    run_n   = run_q;
    hit_n   = 1'b0;
    valid_n = out_valid;
    class_n = out_class;
    data_n  = out_data;
    cm_n    = cnt_match;
    cz_n    = cnt_zero;
    co_n    = cnt_over;

    if (accept_c) begin
      valid_n = 1'b1;
      class_n = class_c;
      data_n  = in_data;
    end else if (out_ready) begin
      valid_n = 1'b0;
    end

    // Clear first so a simultaneous accept still lands as a count of one.
    if (cnt_clr) begin
      cm_n = '0;
      cz_n = '0;
      co_n = '0;
    end
    if (accept_c) begin
      case (class_c)
        CLS_MATCH: cm_n = sat_inc(cm_n);
        CLS_ZERO:  cz_n = sat_inc(cz_n);
        CLS_OVER:  co_n = sat_inc(co_n);
        default:   ;
      endcase
    end

    // HIT lasts one state-cycle and treats a new accept like IDLE.
    case (state_q)
      S_IDLE, S_HIT: begin
        if (accept_c) begin
          if (class_c == CLS_MATCH) begin
            if (RUN_LEN == 1) begin
              state_n = S_HIT;
              run_n   = '0;
              hit_n   = 1'b1;
            end else begin
              state_n = S_RUN;
              run_n   = RUN_W'(1);
            end
          end else begin
            state_n = S_IDLE;
            run_n   = '0;
          end
        end else if (state_q == S_HIT) begin
          state_n = S_IDLE;
        end
      end
      S_RUN: begin
        if (accept_c) begin
          if (class_c == CLS_MATCH) begin
            if (run_inc_c == RUN_LAST) begin
              state_n = S_HIT;
              run_n   = '0;
              hit_n   = 1'b1;
            end else begin
              run_n = run_inc_c;
            end
          end else begin
            state_n = S_IDLE;
            run_n   = '0;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        run_n   = '0;
      end
    endcase
  end

`ifdef SYM_CLASSIFIER_DISPLAY_EN
  // Simulation trace of accepted symbols and completed runs.
  always_ff @(posedge clk) begin
    if (resetn && accept_c) begin
      $display("class=%b data=%h", class_c, in_data);
      if (hit_n) $display("hit at run %0d", RUN_LEN);
    end
  end
`else
  // Trace hooks compiled out.
`endif

endmodule

// File: tb/tb_sym_classifier.sv
module tb_sym_classifier;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  // Instance a: defaults (RUN_LEN=4, CNT_W=16)
  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_hit, a_cnt_clr;
  logic [7:0] a_in_data, a_out_data;
  logic [1:0] a_out_class;
  logic [15:0] a_cm, a_cz, a_co;

  // Instance b: RUN_LEN=1, CNT_W=2
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_hit, b_cnt_clr;
  logic [7:0] b_in_data, b_out_data;
  logic [1:0] b_out_class;
  logic [1:0] b_cm, b_cz, b_co;

  sym_classifier u_a (
    .clk(clk), .resetn(resetn),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_class(a_out_class), .out_data(a_out_data),
    .out_ready(a_out_ready), .hit(a_hit),
    .cnt_match(a_cm), .cnt_zero(a_cz), .cnt_over(a_co), .cnt_clr(a_cnt_clr)
  );

  sym_classifier #(.RUN_LEN(1), .CNT_W(2)) u_b (
    .clk(clk), .resetn(resetn),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_class(b_out_class), .out_data(b_out_data),
    .out_ready(b_out_ready), .hit(b_hit),
    .cnt_match(b_cm), .cnt_zero(b_cz), .cnt_over(b_co), .cnt_clr(b_cnt_clr)
  );

  // Behavioural model: a one-entry output slot plus class tallies and a run length.
  typedef struct {
    bit       v;
    bit [1:0] cls;
    bit [7:0] data;
    bit       hit;
    int       run;
    int       cm, cz, co;
  } model_t;

  typedef struct {
    bit       iv;
    bit [7:0] d;
    bit       ev;
    bit [1:0] ec;
    bit       eh;
  } vec_t;

  model_t ma, mb;
  int checks, errors;
  vec_t tbl[18];

  function automatic model_t mzero();
    model_t z;
    z.v = 0; z.cls = 0; z.data = 0; z.hit = 0; z.run = 0;
    z.cm = 0; z.cz = 0; z.co = 0;
    return z;
  endfunction

  // MATCH_VAL=1, THRESH=1
  function automatic int classify(bit [7:0] d);
    if (d == 8'd1) return 1;
    if (d == 8'd0) return 0;
    if (d > 8'd1)  return 2;
    return 3;
  endfunction

  function automatic int sat(int x, int cmax);
    return (x > cmax) ? cmax : x;
  endfunction

  function automatic model_t mstep(model_t s, bit iv, bit [7:0] d, bit ordy, bit clr,
                                   int run_len, int cmax);
    model_t n;
    bit acc;
    int c;
    n = s;
    acc = iv && (!s.v || ordy);
    n.hit = 0;
    if (clr) begin n.cm = 0; n.cz = 0; n.co = 0; end
    if (acc) begin
      c = classify(d);
      n.v = 1; n.cls = 2'(c); n.data = d;
      if (c == 1) n.cm = sat(n.cm + 1, cmax);
      if (c == 0) n.cz = sat(n.cz + 1, cmax);
      if (c == 2) n.co = sat(n.co + 1, cmax);
      if (c == 1) begin
        n.run = s.run + 1;
        if (n.run == run_len) begin n.hit = 1; n.run = 0; end
      end else begin
        n.run = 0;
      end
    end else if (ordy) begin
      n.v = 0;
    end
    return n;
  endfunction

  function automatic vec_t mk(bit iv, bit [7:0] d, bit ev, bit [1:0] ec, bit eh);
    vec_t r;
    r.iv = iv; r.d = d; r.ev = ev; r.ec = ec; r.eh = eh;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_outs();
    chk("a_out_valid", a_out_valid, ma.v);
    if (ma.v) begin
      chk("a_out_class", a_out_class, ma.cls);
      chk("a_out_data", a_out_data, ma.data);
    end
    chk("a_hit", a_hit, ma.hit);
    chk("a_cnt_match", a_cm, ma.cm);
    chk("a_cnt_zero", a_cz, ma.cz);
    chk("a_cnt_over", a_co, ma.co);
    chk("b_out_valid", b_out_valid, mb.v);
    if (mb.v) begin
      chk("b_out_class", b_out_class, mb.cls);
      chk("b_out_data", b_out_data, mb.data);
    end
    chk("b_hit", b_hit, mb.hit);
    chk("b_cnt_match", b_cm, mb.cm);
    chk("b_cnt_zero", b_cz, mb.cz);
    chk("b_cnt_over", b_co, mb.co);
  endtask

  // One clock: check in_ready before the edge, advance the model, check after it.
  task automatic step();
    model_t na, nb;
    #1;
    chk("a_in_ready", a_in_ready, !ma.v || a_out_ready);
    chk("b_in_ready", b_in_ready, !mb.v || b_out_ready);
    na = mstep(ma, a_in_valid, a_in_data, a_out_ready, a_cnt_clr, 4, 65535);
    nb = mstep(mb, b_in_valid, b_in_data, b_out_ready, b_cnt_clr, 1, 3);
    @(posedge clk);
    #1;
    ma = na;
    mb = nb;
    check_outs();
  endtask

  task automatic idle_inputs();
    a_in_valid = 0; a_in_data = 0; a_out_ready = 1; a_cnt_clr = 0;
    b_in_valid = 0; b_in_data = 0; b_out_ready = 1; b_cnt_clr = 0;
  endtask

  // Asynchronous reset asserted between edges while a result is pending.
  task automatic mid_reset();
    resetn = 0;
    #2;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_class", a_out_class, 0);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_hit", a_hit, 0);
    chk("rst_cnt_match", a_cm, 0);
    chk("rst_cnt_zero", a_cz, 0);
    chk("rst_cnt_over", a_co, 0);
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_b_out_valid", b_out_valid, 0);
    chk("rst_b_cnt_zero", b_cz, 0);
    ma = mzero();
    mb = mzero();
    @(posedge clk);
    #1;
    resetn = 1;
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ma = mzero();
    mb = mzero();
    idle_inputs();
    resetn = 0;
    #12;
    check_outs();
    chk("init_in_ready", a_in_ready, 1);
    resetn = 1;
    @(posedge clk);
    #1;

    // Classification and run detection on instance a.
    tbl[0]  = mk(1, 8'h01, 1, 2'b01, 0);
    tbl[1]  = mk(1, 8'h00, 1, 2'b00, 0);
    tbl[2]  = mk(1, 8'h05, 1, 2'b10, 0);
    tbl[3]  = mk(1, 8'h01, 1, 2'b01, 0);
    tbl[4]  = mk(1, 8'h00, 1, 2'b00, 0);
    tbl[5]  = mk(1, 8'h01, 1, 2'b01, 0);
    tbl[6]  = mk(1, 8'h01, 1, 2'b01, 0);
    tbl[7]  = mk(1, 8'h01, 1, 2'b01, 0);
    tbl[8]  = mk(1, 8'h01, 1, 2'b01, 1);
    tbl[9]  = mk(1, 8'h01, 1, 2'b01, 0);
    tbl[10] = mk(1, 8'h01, 1, 2'b01, 0);
    tbl[11] = mk(1, 8'h01, 1, 2'b01, 0);
    tbl[12] = mk(1, 8'h00, 1, 2'b00, 0);
    tbl[13] = mk(1, 8'h01, 1, 2'b01, 0);
    tbl[14] = mk(1, 8'h01, 1, 2'b01, 0);
    tbl[15] = mk(1, 8'h01, 1, 2'b01, 0);
    tbl[16] = mk(1, 8'h01, 1, 2'b01, 1);
    tbl[17] = mk(0, 8'h00, 0, 2'b00, 0);
    for (int i = 0; i < 18; i++) begin
      a_in_valid = tbl[i].iv;
      a_in_data  = tbl[i].d;
      step();
      chk("tbl_valid", a_out_valid, tbl[i].ev);
      if (tbl[i].ev) chk("tbl_class", a_out_class, tbl[i].ec);
      chk("tbl_hit", a_hit, tbl[i].eh);
      if (i == 3) begin
        chk("tbl_cnt_match", a_cm, 2);
        chk("tbl_cnt_zero", a_cz, 1);
        chk("tbl_cnt_over", a_co, 1);
      end
    end
    chk("tbl_final_cnt_match", a_cm, 13);
    chk("tbl_final_cnt_zero", a_cz, 3);

    // Backpressure: result held, input stalled, nothing lost.
    a_out_ready = 0; a_in_valid = 1; a_in_data = 8'h05;
    step();
    chk("bp_first_data", a_out_data, 8'h05);
    a_in_data = 8'h00;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_in_ready", a_in_ready, 0);
      chk("bp_out_valid", a_out_valid, 1);
      chk("bp_out_data", a_out_data, 8'h05);
      chk("bp_out_class", a_out_class, 2'b10);
    end
    a_out_ready = 1;
    step();
    chk("bp_next_data", a_out_data, 8'h00);
    chk("bp_next_class", a_out_class, 2'b00);
    a_in_valid = 0;
    step();

    // Saturation at CNT_W=2, clear with and without a same-cycle accept.
    b_in_valid = 1; b_in_data = 8'h00;
    for (int i = 0; i < 5; i++) step();
    chk("sat_cnt_zero", b_cz, 3);
    b_cnt_clr = 1;
    step();
    chk("clr_acc_cnt_zero", b_cz, 1);
    b_in_valid = 0;
    step();
    chk("clr_only_cnt_zero", b_cz, 0);
    b_cnt_clr = 0;

    // RUN_LEN=1: back-to-back hits, then a hit under backpressure lasts one cycle.
    b_in_valid = 1; b_in_data = 8'h01;
    step(); chk("r1_hit_first", b_hit, 1);
    step(); chk("r1_hit_second", b_hit, 1);
    b_in_valid = 0;
    step(); chk("r1_hit_drop", b_hit, 0);
    b_out_ready = 0; b_in_valid = 1;
    step(); chk("r1_bp_hit", b_hit, 1);
    step(); chk("r1_bp_hit_drop", b_hit, 0);
    chk("r1_bp_valid", b_out_valid, 1);
    b_out_ready = 1; b_in_valid = 0;
    step();

    // Reset in the middle of a stalled stream.
    a_out_ready = 0; a_in_valid = 1; a_in_data = 8'h01;
    step();
    mid_reset();
    step();

    // Randomised traffic on both instances.
    for (int i = 0; i < 3000; i++) begin
      a_in_valid  = ($urandom_range(0, 3) != 0);
      b_in_valid  = ($urandom_range(0, 3) != 0);
      a_out_ready = ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 3) != 0);
      a_cnt_clr   = ($urandom_range(0, 63) == 0);
      b_cnt_clr   = ($urandom_range(0, 63) == 0);
      case ($urandom_range(0, 3))
        0:       a_in_data = 8'h00;
        1, 2:    a_in_data = 8'h01;
        default: a_in_data = 8'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0:       b_in_data = 8'h00;
        1:       b_in_data = 8'h01;
        default: b_in_data = 8'($urandom);
      endcase
      if (i == 1500) mid_reset();
      else step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
